// File: rtl/fpu_cw_sequencer_if.sv
// ---------------------------------------------------------------------------
// fpu_cw_sequencer_if
//   Memory read/write handshake between the FPU control-word sequencer and
//   the memory system. The sequencer drives one strobe at a time and holds
//   it until the memory returns a single-cycle acknowledge.
//
// Signals:
//   mem_rd_req   read strobe, held until mem_ack
//   mem_wr_req   write strobe, held until mem_ack
//   mem_addr     word address (ADDR_WIDTH bits)
//   mem_wr_data  16-bit store data
//   mem_rd_data  16-bit load data, valid with mem_ack
//   mem_ack      one-cycle acknowledge
//
// Modports:
//   master  sequencer side
//   slave   memory side
// ---------------------------------------------------------------------------
interface fpu_cw_sequencer_if #(
  parameter int ADDR_WIDTH = 20
);
  logic                  mem_rd_req;
  logic                  mem_wr_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_wr_data;
  logic [15:0]           mem_rd_data;
  logic                  mem_ack;

  modport master (
    output mem_rd_req,
    output mem_wr_req,
    output mem_addr,
    output mem_wr_data,
    input  mem_rd_data,
    input  mem_ack
  );

  modport slave (
    input  mem_rd_req,
    input  mem_wr_req,
    input  mem_addr,
    input  mem_wr_data,
    output mem_rd_data,
    output mem_ack
  );
endinterface

// File: rtl/fpu_cw_sequencer.sv
// ---------------------------------------------------------------------------
// fpu_cw_sequencer
//   Sequences every access to the 8087 FPU control word (CW): FLDCW (memory
//   to CW), FSTCW (CW to memory) and FINIT (CW to DEFAULT_CW). Two requesters
//   (host CPU escape interface and FPU microsequencer) are arbitrated
//   round-robin. A newly loaded CW that unmasks an already-pending exception
//   raises a sticky int_req.
//
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   cpu_req/op/addr, cpu_done  host request (level) and completion pulse
//   uc_req/op/addr, uc_done    microsequencer request and completion pulse
//   err                        pulse with done on timeout or illegal op
//   mem                        memory handshake (fpu_cw_sequencer_if.master)
//   cw_cur                     current CW register contents
//   cw_wdata, cw_we            CW register write port
//   exc_pending                status-word exception flags PE UE OE ZE DE IE
//   int_req, int_clr           sticky interrupt request and its clear
//   busy                       high whenever a transaction is in flight
//
// Build option:
//   FPU_CW_RESERVED_FIX_EN  when defined, loaded CW values have reserved bits
//                           [15:12] and [7] forced to 0 and bit 6 forced to 1.
//
// Op encoding: 00 FLDCW, 01 FSTCW, 10 FINIT, 11 illegal.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a request; arbitration and operand latch
// RD    | FLDCW memory read strobe held until ack or timeout
// LOAD  | one-cycle CW write of captured/default value
// CHK   | compare new CW masks against pending exceptions
// WR    | FSTCW memory write strobe held until ack or timeout
// DONE  | one-cycle done (and err) pulse to the owner
// ---------------------------------------------------------------------------
module fpu_cw_sequencer #(
  parameter int          ADDR_WIDTH = 20,
  parameter int          TIMEOUT    = 255,
  parameter logic [15:0] DEFAULT_CW = 16'h037F
) (
  input  logic                  clk,
  input  logic                  reset_n,

  input  logic                  cpu_req,
  input  logic [1:0]            cpu_op,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic                  cpu_done,

  input  logic                  uc_req,
  input  logic [1:0]            uc_op,
  input  logic [ADDR_WIDTH-1:0] uc_addr,
  output logic                  uc_done,

  output logic                  err,

  fpu_cw_sequencer_if.master    mem,

  input  logic [15:0]           cw_cur,
  output logic [15:0]           cw_wdata,
  output logic                  cw_we,

  input  logic [5:0]            exc_pending,
  output logic                  int_req,
  input  logic                  int_clr,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_LOAD,
    S_CHK,
    S_WR,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_FLDCW = 2'b00;
  localparam logic [1:0] OP_FSTCW = 2'b01;
  localparam logic [1:0] OP_FINIT = 2'b10;
  localparam logic [7:0] TMR_INIT = 8'(TIMEOUT);

  function automatic logic [15:0] fix_cw(input logic [15:0] d);
`ifdef FPU_CW_RESERVED_FIX_EN
    fix_cw = (d & 16'h0F3F) | 16'h0040;
`else
    fix_cw = d;
`endif
  endfunction

  state_t                state_q, state_d;
  logic                  last_uc_q;   // 1: microsequencer was granted last
  logic                  owner_uc_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           wr_data_q;
  logic [15:0]           cw_data_q;
  logic [7:0]            tmr_q;
  logic                  err_q;
  logic                  int_req_q;

  logic                  grant;
  logic                  grant_uc;
  logic [1:0]            sel_op;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  set_err;
  logic                  ld_tmr;
  logic                  dec_tmr;
  logic                  cap_rd;
  logic                  int_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    grant_uc = 1'b0;
    sel_op   = cpu_op;
    sel_addr = cpu_addr;
    set_err  = 1'b0;
    ld_tmr   = 1'b0;
    dec_tmr  = 1'b0;
    cap_rd   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cpu_req || uc_req) begin
          grant    = 1'b1;
          // On a tie the requester that was not granted last wins.
          grant_uc = uc_req && (!cpu_req || !last_uc_q);
          sel_op   = grant_uc ? uc_op : cpu_op;
          sel_addr = grant_uc ? uc_addr : cpu_addr;
          case (sel_op)
            OP_FLDCW: begin
              state_d = S_RD;
              ld_tmr  = 1'b1;
            end
            OP_FSTCW: begin
              state_d = S_WR;
              ld_tmr  = 1'b1;
            end
            OP_FINIT: state_d = S_LOAD;
            default: begin
              state_d = S_DONE;
              set_err = 1'b1;
            end
          endcase
        end
      end

      S_RD: begin
        // An ack on the final allowed cycle still completes the load.
        if (mem.mem_ack) begin
          cap_rd  = 1'b1;
          state_d = S_LOAD;
        end else if (tmr_q == 8'd1) begin
          set_err = 1'b1;
          state_d = S_DONE;
        end else begin
          dec_tmr = 1'b1;
        end
      end

      S_WR: begin
        if (mem.mem_ack) begin
          state_d = S_DONE;
        end else if (tmr_q == 8'd1) begin
          set_err = 1'b1;
          state_d = S_DONE;
        end else begin
          dec_tmr = 1'b1;
        end
      end

      S_LOAD:  state_d = S_CHK;
      S_CHK:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_uc_q  <= 1'b0;
      owner_uc_q <= 1'b0;
      addr_q     <= '0;
      wr_data_q  <= '0;
      cw_data_q  <= '0;
      tmr_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= set_err;
      if (grant) begin
        last_uc_q  <= grant_uc;
        owner_uc_q <= grant_uc;
        addr_q     <= sel_addr;
        wr_data_q  <= cw_cur;
        if (sel_op == OP_FINIT) cw_data_q <= fix_cw(DEFAULT_CW);
      end
      if (cap_rd) cw_data_q <= fix_cw(mem.mem_rd_data);
      if (ld_tmr)       tmr_q <= TMR_INIT;
      else if (dec_tmr) tmr_q <= tmr_q - 8'd1;
    end
  end

  // A '1' in CW[5:0] masks the matching exception; any pending flag whose
  // mask bit is now clear must be reported.
  assign int_hit = (state_q == S_CHK) && ((exc_pending & ~cw_data_q[5:0]) != 6'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     int_req_q <= 1'b0;
    else if (int_hit) int_req_q <= 1'b1;
    else if (int_clr) int_req_q <= 1'b0;
  end

  assign mem.mem_rd_req  = (state_q == S_RD);
  assign mem.mem_wr_req  = (state_q == S_WR);
  assign mem.mem_addr    = addr_q;
  assign mem.mem_wr_data = wr_data_q;

  assign cw_we    = (state_q == S_LOAD);
  assign cw_wdata = cw_data_q;
  assign cpu_done = (state_q == S_DONE) && !owner_uc_q;
  assign uc_done  = (state_q == S_DONE) && owner_uc_q;
  assign err      = err_q;
  assign int_req  = int_req_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_fpu_cw_sequencer.sv
module tb_fpu_cw_sequencer;
  localparam int AW = 20;

`ifdef FPU_CW_RESERVED_FIX_EN
  localparam logic [15:0] EXP_FF = 16'h0F7F;
`else
  localparam logic [15:0] EXP_FF = 16'hFFFF;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cpu_req = 1'b0, uc_req = 1'b0;
  logic [1:0]    cpu_op = '0, uc_op = '0;
  logic [AW-1:0] cpu_addr = '0, uc_addr = '0;
  logic          cpu_done, uc_done, err;
  logic [15:0]   cw_cur = '0;
  logic [15:0]   cw_wdata;
  logic          cw_we;
  logic [5:0]    exc_pending = '0;
  logic          int_req;
  logic          int_clr = 1'b0;
  logic          busy;

  always #5 clk = ~clk;

  fpu_cw_sequencer_if #(.ADDR_WIDTH(AW)) mem_if ();

  fpu_cw_sequencer #(.ADDR_WIDTH(AW), .TIMEOUT(255), .DEFAULT_CW(16'h037F)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_req    (cpu_req),
    .cpu_op     (cpu_op),
    .cpu_addr   (cpu_addr),
    .cpu_done   (cpu_done),
    .uc_req     (uc_req),
    .uc_op      (uc_op),
    .uc_addr    (uc_addr),
    .uc_done    (uc_done),
    .err        (err),
    .mem        (mem_if),
    .cw_cur     (cw_cur),
    .cw_wdata   (cw_wdata),
    .cw_we      (cw_we),
    .exc_pending(exc_pending),
    .int_req    (int_req),
    .int_clr    (int_clr),
    .busy       (busy)
  );

  // CW register model: the bench owns the register the sequencer writes.
  always @(posedge clk) if (cw_we) cw_cur <= cw_wdata;

  typedef struct {
    bit          uc;
    bit          err;
    int          lat;
    int          we;
    logic [15:0] we_data;
    int          rd_cyc;
    int          wr_cyc;
    logic [15:0] wr_data;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic exp_t mk(bit uc, bit e, int lat, int we, logic [15:0] wd,
                              int rd, int wr, logic [15:0] wrd, logic [AW-1:0] a);
    exp_t x;
    x.uc = uc; x.err = e; x.lat = lat; x.we = we; x.we_data = wd;
    x.rd_cyc = rd; x.wr_cyc = wr; x.wr_data = wrd; x.addr = a;
    return x;
  endfunction

  // Memory responder: ack arrives wait_states cycles after the cycle
  // following the strobe's rise; no_ack models a dead memory.
  int wait_states = 0;
  bit no_ack = 1'b0;
  int age = 0;
  logic [15:0] rd_value = '0;

  initial begin
    mem_if.mem_ack = 1'b0;
    mem_if.mem_rd_data = '0;
  end

  always @(posedge clk) begin
    #1;
    mem_if.mem_rd_data = rd_value;
    if (mem_if.mem_ack) begin
      mem_if.mem_ack = 1'b0;
      age = 0;
    end else if ((mem_if.mem_rd_req || mem_if.mem_wr_req) && !no_ack) begin
      age++;
      if (age == wait_states + 2) mem_if.mem_ack = 1'b1;
    end else begin
      age = 0;
    end
  end

  // Monitor: accumulates per-transaction observations, checks on done.
  int busy_cnt = 0, we_cnt = 0, rd_cyc = 0, wr_cyc = 0;
  logic [15:0] we_d = '0, wr_d = '0;
  logic [AW-1:0] addr_seen = '0;
  exp_t e;

  always @(negedge clk) begin
    if (mem_if.mem_rd_req && mem_if.mem_wr_req) flag("both_strobes_high");
    if (cpu_done && uc_done) flag("both_done_high");
    if (err && !(cpu_done || uc_done)) flag("err_without_done");
    if (cw_we && !busy) flag("cw_we_while_idle");
    if (!busy) begin
      busy_cnt = 0; we_cnt = 0; rd_cyc = 0; wr_cyc = 0;
    end else begin
      busy_cnt++;
      if (cw_we) begin we_cnt++; we_d = cw_wdata; end
      if (mem_if.mem_rd_req) begin rd_cyc++; addr_seen = mem_if.mem_addr; end
      if (mem_if.mem_wr_req) begin
        wr_cyc++; addr_seen = mem_if.mem_addr; wr_d = mem_if.mem_wr_data;
      end
      if (cpu_done || uc_done) begin
        if (sb.size() == 0) flag("unexpected_done");
        else begin
          e = sb.pop_front();
          chk("owner_is_uc", 32'(uc_done), 32'(e.uc));
          chk("err", 32'(err), 32'(e.err));
          chk("latency", busy_cnt, e.lat);
          chk("cw_we_count", we_cnt, e.we);
          if (e.we > 0) chk("cw_wdata", 32'(we_d), 32'(e.we_data));
          chk("rd_strobe_cycles", rd_cyc, e.rd_cyc);
          chk("wr_strobe_cycles", wr_cyc, e.wr_cyc);
          if (e.wr_cyc > 0) chk("mem_wr_data", 32'(wr_d), 32'(e.wr_data));
          if (e.rd_cyc > 0 || e.wr_cyc > 0) chk("mem_addr", 32'(addr_seen), 32'(e.addr));
        end
      end
    end
  end

  task automatic start(input bit uc, input logic [1:0] op, input logic [AW-1:0] a);
    if (uc) begin uc_req = 1'b1; uc_op = op; uc_addr = a; end
    else    begin cpu_req = 1'b1; cpu_op = op; cpu_addr = a; end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      if (cpu_done) cpu_req = 1'b0;
      if (uc_done)  uc_req  = 1'b0;
      n++;
    end while ((cpu_req || uc_req || busy) && n < budget);
    if (cpu_req || uc_req || busy) begin
      flag("wait_for_done_expired");
      cpu_req = 1'b0;
      uc_req  = 1'b0;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'({cpu_done, uc_done}), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_strobes"}, 32'({mem_if.mem_rd_req, mem_if.mem_wr_req}), 0);
    chk({tag, "_cw_we"}, 32'(cw_we), 0);
    chk({tag, "_cw_wdata"}, 32'(cw_wdata), 0);
    chk({tag, "_mem_addr"}, 32'(mem_if.mem_addr), 0);
    chk({tag, "_mem_wr_data"}, 32'(mem_if.mem_wr_data), 0);
    chk({tag, "_int_req"}, 32'(int_req), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // FINIT with every exception pending: default CW masks them all.
    exc_pending = 6'h3F;
    sb.push_back(mk(0, 0, 3, 1, 16'h037F, 0, 0, 16'h0, '0));
    start(0, 2'b10, '0);
    wait_idle(20);
    chk("int_req_after_finit", 32'(int_req), 0);
    exc_pending = 6'h00;

    // Two rounds of simultaneous FSTCW: uc first (cpu was last), then cpu.
    for (int r = 0; r < 2; r++) begin
      sb.push_back(mk(1, 0, 3, 0, 16'h0, 0, 2, 16'h037F, 20'h00200));
      sb.push_back(mk(0, 0, 3, 0, 16'h0, 0, 2, 16'h037F, 20'h00300));
      start(1, 2'b01, 20'h00200);
      start(0, 2'b01, 20'h00300);
      wait_idle(40);
    end

    // uc FLDCW, one wait state, IE pending and unmasked by 0x0C7E.
    wait_states = 1;
    rd_value = 16'h0C7E;
    exc_pending = 6'h01;
    sb.push_back(mk(1, 0, 6, 1, 16'h0C7E, 3, 0, 16'h0, 20'h00100));
    start(1, 2'b00, 20'h00100);
    wait_idle(30);
    chk("int_req_set_by_fldcw", 32'(int_req), 1);
    int_clr = 1'b1;
    @(negedge clk);
    int_clr = 1'b0;
    chk("int_req_cleared", 32'(int_req), 0);
    exc_pending = 6'h00;
    wait_states = 0;

    // FLDCW into a dead memory: 255 strobe cycles then err with done.
    no_ack = 1'b1;
    sb.push_back(mk(0, 1, 256, 0, 16'h0, 255, 0, 16'h0, 20'h00400));
    start(0, 2'b00, 20'h00400);
    wait_idle(400);
    no_ack = 1'b0;

    // Illegal op: done and err in the cycle after grant.
    sb.push_back(mk(1, 1, 1, 0, 16'h0, 0, 0, 16'h0, '0));
    start(1, 2'b11, 20'h00AAA);
    wait_idle(20);

    // FLDCW of all ones: reserved-bit handling, all exceptions still masked.
    rd_value = 16'hFFFF;
    exc_pending = 6'h3F;
    sb.push_back(mk(0, 0, 5, 1, EXP_FF, 2, 0, 16'h0, 20'h00500));
    start(0, 2'b00, 20'h00500);
    wait_idle(30);
    chk("int_req_after_ffff", 32'(int_req), 0);
    exc_pending = 6'h00;

    // FSTCW stores the register as-is.
    sb.push_back(mk(1, 0, 3, 0, 16'h0, 0, 2, EXP_FF, 20'h00600));
    start(1, 2'b01, 20'h00600);
    wait_idle(20);

    // Reset in the middle of an FLDCW: everything drops at once.
    no_ack = 1'b1;
    start(0, 2'b00, 20'h00700);
    repeat (5) @(negedge clk);
    chk("busy_before_reset", 32'(busy), 1);
    reset_n = 1'b0;
    #1;
    chk_all_zero("midop_reset");
    cpu_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    no_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_done_after_reset", 32'(busy), 0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fpu_cw_sequencer.md
Name: fpu_cw_sequencer

Overview:
- Sequences every access to the 8087 FPU control word register: FLDCW (memory to CW), FSTCW (CW to memory) and FINIT (CW set to default).
- Arbitrates between two requesters: the host CPU escape interface and the FPU microsequencer.
- Drives the CW register's write port and a 16-bit memory read/write handshake.
- Raises int_req when a newly loaded CW unmasks an already-pending exception.

Parameters:
ADDR_WIDTH, 20, memory word address width.
TIMEOUT, 255, maximum cycles to wait for a memory ack before aborting (8-bit counter, 1..255).
DEFAULT_CW, 16'h037F, value written by FINIT.

Ports:
clk  in  1  clock; all state updates on its rising edge.
reset_n  in  1  asynchronous, active-low reset.
cpu_req  in  1  host request; level, held until cpu_done.
cpu_op  in  2  00 FLDCW, 01 FSTCW, 10 FINIT, 11 illegal.
cpu_addr  in  ADDR_WIDTH  memory address for FLDCW/FSTCW.
cpu_done  out  1  one-cycle completion pulse to host.
uc_req  in  1  microsequencer request; same rules as cpu_req.
uc_op  in  2  same encoding as cpu_op.
uc_addr  in  ADDR_WIDTH  same as cpu_addr.
uc_done  out  1  one-cycle completion pulse to microsequencer.
err  out  1  one-cycle pulse, coincident with done, on timeout or illegal op.
mem_rd_req  out  1  read strobe, level until ack.
mem_wr_req  out  1  write strobe, level until ack.
mem_addr  out  ADDR_WIDTH  registered address.
mem_wr_data  out  16  registered store data.
mem_rd_data  in  16  read data, valid with mem_ack.
mem_ack  in  1  one-cycle acknowledge.
cw_cur  in  16  current CW (register control_out).
cw_wdata  out  16  CW write data.
cw_we  out  1  one-cycle CW write enable.
exc_pending  in  6  status-word exception flags [5:0] (PE UE OE ZE DE IE).
int_req  out  1  sticky interrupt request.
int_clr  in  1  clears int_req.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, reset_n low): state IDLE; all outputs 0; last_grant = CPU, so the microsequencer wins the first tie. Reset mid-operation abandons the transaction; no cw_we or done is issued.
- States: IDLE, RD, LOAD, CHK, WR, DONE.
- IDLE arbitration:
  - One requester active: it is granted.
  - Both active: round-robin; the requester not granted last wins.
  - On grant: op, addr and owner are latched. mem_addr is updated only on a grant.
- Transitions by latched op:
  - FLDCW: IDLE -> RD. mem_rd_req = 1 until mem_ack; data is captured on ack -> LOAD.
  - LOAD: cw_we = 1 for one cycle, cw_wdata = captured data -> CHK.
  - CHK: if (exc_pending & ~new_cw[5:0]) != 0, set int_req -> DONE.
  - FSTCW: IDLE -> WR. mem_wr_data = cw_cur sampled at grant; mem_wr_req = 1 until mem_ack -> DONE.
  - FINIT: IDLE -> LOAD with cw_wdata = DEFAULT_CW, then CHK. DEFAULT_CW masks all exceptions, so int_req is never newly set.
  - Illegal op: IDLE -> DONE with err.
- DONE: owner's done pulses for 1 cycle -> IDLE. A requester still asserting req in the cycle after its done is treated as a new request.
- Latency with zero-wait memory (ack the cycle after the strobe rises):
  - FLDCW: done 5 cycles after grant.
  - FSTCW: done 3 cycles after grant.
  - FINIT: done 3 cycles after grant.
- Timeout:
  - The counter resets on entering RD or WR.
  - If TIMEOUT cycles pass without ack: strobe drops, no cw_we, go to DONE with err = 1.
  - mem_ack outside RD/WR is ignored.
- int_req: set in CHK, cleared by int_clr. If set and clear coincide, set wins.
- cw_we never asserts outside LOAD. Only one memory strobe is ever high.

Optional Feature:
FPU_CW_RESERVED_FIX_EN
- Defined: the value written in LOAD is (data & 16'h0F3F) | 16'h0040, so reserved bits [15:12] and [7] read 0 and bit 6 reads 1, as on the 8087. FSTCW stores cw_cur unmodified.
- Undefined: all 16 bits pass through unchanged.

Test Plan:
- Reset, then cpu FINIT -> cw_we with cw_wdata = 16'h037F; cpu_done 3 cycles after grant; int_req stays 0 even with exc_pending = 6'h3F.
- uc FLDCW at addr 0x00100, mem returns 16'h0C7E with 1 wait state, exc_pending = 6'h01 -> cw_wdata = 0x0C7E, int_req = 1 (IE unmasked); int_clr drops it next cycle.
- cpu and uc both request FSTCW in the same cycle, twice in a row -> first grant uc, second grant cpu; mem_wr_data = cw_cur (0x037F) each time; done pulses go to the correct owners.
- FLDCW with no mem_ack -> mem_rd_req high exactly 255 cycles, then err and done together, no cw_we.
- Illegal op 11 -> done + err 1 cycle after grant. Then reset_n pulsed low mid-FLDCW -> all outputs 0 immediately, busy = 0.
- With FPU_CW_RESERVED_FIX_EN, FLDCW of 16'hFFFF -> cw_wdata = 16'h0F7F. Without the macro -> 16'hFFFF.
